// File: rtl/register_file_pkg.sv
// Shared CPU constants: ROB tag width, architectural register count, index/data widths.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package register_file_pkg;

    localparam int ROB_WIDTH = 4;   // reorder-buffer tag width
    localparam int REG_COUNT = 32;  // architectural registers
    localparam int REG_IDX_W = 5;   // register index width
    localparam int DATA_W    = 32;  // register value width

    typedef logic [REG_IDX_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

endpackage

// File: rtl/register_file_if.sv
// Register-file bus: commit port (from ROB), rename port (from issue), flush, two read ports.
// Latency: wires only; reads are combinational in the register file.
// Backpressure: none; all strobes are accepted unconditionally.
// Modports: master drives commit/rename/clear/read indices, slave returns read results.
interface register_file_if #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH
);
    import register_file_pkg::*;

    logic                 clear;
    logic                 regUpdateValid;
    reg_idx_t             regUpdateDest;
    reg_data_t            regValue;
    logic [ROB_WIDTH-1:0] regUpdateRobId;
    logic                 renameValid;
    reg_idx_t             renameDest;
    logic [ROB_WIDTH-1:0] renameRobId;
    reg_idx_t             rs1Index;
    logic                 rs1Busy;
    logic [ROB_WIDTH-1:0] rs1Dep;
    reg_data_t            rs1Value;
    reg_idx_t             rs2Index;
    logic                 rs2Busy;
    logic [ROB_WIDTH-1:0] rs2Dep;
    reg_data_t            rs2Value;

    modport master (
        output clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        output renameValid, renameDest, renameRobId, rs1Index, rs2Index,
        input  rs1Busy, rs1Dep, rs1Value, rs2Busy, rs2Dep, rs2Value
    );

    modport slave (
        input  clear, regUpdateValid, regUpdateDest, regValue, regUpdateRobId,
        input  renameValid, renameDest, renameRobId, rs1Index, rs2Index,
        output rs1Busy, rs1Dep, rs1Value, rs2Busy, rs2Dep, rs2Value
    );

endinterface

// File: rtl/register_file_reg_read_port.sv
// One register-file read port: selects value/busy/tag for rs_index, x0 reads as zero.
// Latency: combinational. With REG_FILE_BYPASS_EN a same-cycle matching commit is forwarded.
// Backpressure: none.
// Ports: registered state arrays in, rs_index in, rs_busy/rs_dep/rs_value out; commit/rename/clear
// inputs exist only when REG_FILE_BYPASS_EN is defined.
module reg_read_port #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH,
    parameter int REG_COUNT = register_file_pkg::REG_COUNT
) (
    input  register_file_pkg::reg_data_t value_q [REG_COUNT],
    input  logic [REG_COUNT-1:0]         busy_q,
    input  logic [ROB_WIDTH-1:0]         tag_q   [REG_COUNT],
`ifdef REG_FILE_BYPASS_EN
    input  logic                         clear,
    input  logic                         commit_vld,
    input  register_file_pkg::reg_idx_t  commit_dest,
    input  register_file_pkg::reg_data_t commit_value,
    input  logic [ROB_WIDTH-1:0]         commit_rob,
    input  logic                         rename_vld,
    input  register_file_pkg::reg_idx_t  rename_dest,
    input  logic [ROB_WIDTH-1:0]         rename_rob,
`endif
    input  register_file_pkg::reg_idx_t  rs_index,
    output logic                         rs_busy,
    output logic [ROB_WIDTH-1:0]         rs_dep,
    output register_file_pkg::reg_data_t rs_value
);

    always_comb begin
        rs_busy  = 1'b0;
        rs_dep   = '0;
        rs_value = '0;
        if (rs_index != '0) begin
            rs_value = value_q[rs_index];
            rs_busy  = busy_q[rs_index];
            rs_dep   = tag_q[rs_index];
`ifdef REG_FILE_BYPASS_EN
            // Forward only the commit that will actually retire the in-flight producer.
            if (commit_vld && (commit_dest == rs_index) && busy_q[rs_index] &&
                (tag_q[rs_index] == commit_rob)) begin
                rs_value = commit_value;
                rs_busy  = 1'b0;
                // A same-cycle rename re-busies the register; report the new producer.
                if (rename_vld && !clear && (rename_dest == rs_index)) begin
                    rs_busy = 1'b1;
                    rs_dep  = rename_rob;
                end
            end
`endif
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file with per-register busy bit and producing ROB tag (rename table).
// Latency: reads combinational; commit/rename/clear take effect at the next rising clockIn.
// Backpressure: none; every strobe is accepted. Optional macro: REG_FILE_BYPASS_EN (commit forwarding).
// Ports: clockIn, resetIn (async active-low), bus (register_file_if.slave).
module register_file #(
    parameter int ROB_WIDTH = register_file_pkg::ROB_WIDTH,
    parameter int REG_COUNT = register_file_pkg::REG_COUNT
) (
    input logic              clockIn,
    input logic              resetIn,
    register_file_if.slave   bus
);
    import register_file_pkg::*;

    reg_data_t            value_q [REG_COUNT];
    reg_data_t            value_d [REG_COUNT];
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic [ROB_WIDTH-1:0] tag_q   [REG_COUNT];
    logic [ROB_WIDTH-1:0] tag_d   [REG_COUNT];

    logic commit_en;
    logic rename_en;

    // Writes to x0 are dropped so it stays at its reset value of zero.
    assign commit_en = bus.regUpdateValid && (bus.regUpdateDest != '0);
    assign rename_en = bus.renameValid && (bus.renameDest != '0) && !bus.clear;

    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        if (commit_en) begin
            value_d[bus.regUpdateDest] = bus.regValue;
            // A stale commit (register since renamed) must not release the newer producer.
            if (tag_q[bus.regUpdateDest] == bus.regUpdateRobId) begin
                busy_d[bus.regUpdateDest] = 1'b0;
            end
        end
        if (bus.clear) begin
            busy_d = '0;
        end else if (rename_en) begin
            // Applied after the commit so a same-register rename wins busy/tag.
            busy_d[bus.renameDest] = 1'b1;
            tag_d[bus.renameDest]  = bus.renameRobId;
        end
    end

    always_ff @(posedge clockIn or negedge resetIn) begin
        if (!resetIn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            busy_q <= '0;
        end else begin
            value_q <= value_d;
            busy_q  <= busy_d;
            tag_q   <= tag_d;
        end
    end

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_COUNT(REG_COUNT)) u_rd1 (
        .value_q      (value_q),
        .busy_q       (busy_q),
        .tag_q        (tag_q),
`ifdef REG_FILE_BYPASS_EN
        .clear        (bus.clear),
        .commit_vld   (bus.regUpdateValid),
        .commit_dest  (bus.regUpdateDest),
        .commit_value (bus.regValue),
        .commit_rob   (bus.regUpdateRobId),
        .rename_vld   (bus.renameValid),
        .rename_dest  (bus.renameDest),
        .rename_rob   (bus.renameRobId),
`endif
        .rs_index     (bus.rs1Index),
        .rs_busy      (bus.rs1Busy),
        .rs_dep       (bus.rs1Dep),
        .rs_value     (bus.rs1Value)
    );

    reg_read_port #(.ROB_WIDTH(ROB_WIDTH), .REG_COUNT(REG_COUNT)) u_rd2 (
        .value_q      (value_q),
        .busy_q       (busy_q),
        .tag_q        (tag_q),
`ifdef REG_FILE_BYPASS_EN
        .clear        (bus.clear),
        .commit_vld   (bus.regUpdateValid),
        .commit_dest  (bus.regUpdateDest),
        .commit_value (bus.regValue),
        .commit_rob   (bus.regUpdateRobId),
        .rename_vld   (bus.renameValid),
        .rename_dest  (bus.renameDest),
        .rename_rob   (bus.renameRobId),
`endif
        .rs_index     (bus.rs2Index),
        .rs_busy      (bus.rs2Busy),
        .rs_dep       (bus.rs2Dep),
        .rs_value     (bus.rs2Value)
    );

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register/rename table.
// Expectations for the commit-forwarding case follow REG_FILE_BYPASS_EN.
module tb_register_file;

    logic clockIn = 1'b0;
    logic resetIn;

    always #5 clockIn = ~clockIn;

    register_file_if #(.ROB_WIDTH(4)) bus ();

    register_file #(.ROB_WIDTH(4), .REG_COUNT(32)) dut (
        .clockIn (clockIn),
        .resetIn (resetIn),
        .bus     (bus)
    );

    // Reference model state.
    logic [31:0] m_val  [32];
    logic        m_busy [32];
    logic [3:0]  m_tag  [32];

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_val[i]  = 32'h0;
            m_busy[i] = 1'b0;
            m_tag[i]  = 4'h0;
        end
    endtask

    // Edge update: commit (against the pre-edge tag), then flush or rename.
    task automatic model_step();
        int cd, rd;
        cd = int'(bus.regUpdateDest);
        rd = int'(bus.renameDest);
        if (bus.regUpdateValid && cd != 0) begin
            m_val[cd] = bus.regValue;
            if (m_tag[cd] == bus.regUpdateRobId) m_busy[cd] = 1'b0;
        end
        if (bus.clear) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
        end else if (bus.renameValid && rd != 0) begin
            m_busy[rd] = 1'b1;
            m_tag[rd]  = bus.renameRobId;
        end
    endtask

    task automatic exp_read(input logic [4:0] idx, output logic b, output logic [3:0] d,
                            output logic [31:0] v);
        int i;
        i = int'(idx);
        b = 1'b0; d = 4'h0; v = 32'h0;
        if (resetIn && i != 0) begin
            b = m_busy[i]; d = m_tag[i]; v = m_val[i];
`ifdef REG_FILE_BYPASS_EN
            if (bus.regUpdateValid && bus.regUpdateDest == idx && m_busy[i] &&
                m_tag[i] == bus.regUpdateRobId) begin
                v = bus.regValue;
                b = 1'b0;
                if (bus.renameValid && !bus.clear && bus.renameDest == idx) begin
                    b = 1'b1;
                    d = bus.renameRobId;
                end
            end
`endif
        end
    endtask

    task automatic compare_ports();
        logic b; logic [3:0] d; logic [31:0] v;
        exp_read(bus.rs1Index, b, d, v);
        check_eq("rs1_busy", 32'(bus.rs1Busy), 32'(b));
        if (b) check_eq("rs1_dep", 32'(bus.rs1Dep), 32'(d));
        check_eq("rs1_value", bus.rs1Value, v);
        exp_read(bus.rs2Index, b, d, v);
        check_eq("rs2_busy", 32'(bus.rs2Busy), 32'(b));
        if (b) check_eq("rs2_dep", 32'(bus.rs2Dep), 32'(d));
        check_eq("rs2_value", bus.rs2Value, v);
    endtask

    task automatic drive_idle();
        bus.clear          = 1'b0;
        bus.regUpdateValid = 1'b0;
        bus.regUpdateDest  = 5'd0;
        bus.regValue       = 32'h0;
        bus.regUpdateRobId = 4'h0;
        bus.renameValid    = 1'b0;
        bus.renameDest     = 5'd0;
        bus.renameRobId    = 4'h0;
        bus.rs1Index       = 5'd0;
        bus.rs2Index       = 5'd0;
    endtask

    task automatic drive_commit(input logic [4:0] dest, input logic [3:0] rob, input logic [31:0] val);
        bus.regUpdateValid = 1'b1;
        bus.regUpdateDest  = dest;
        bus.regUpdateRobId = rob;
        bus.regValue       = val;
    endtask

    task automatic drive_rename(input logic [4:0] dest, input logic [3:0] rob);
        bus.renameValid = 1'b1;
        bus.renameDest  = dest;
        bus.renameRobId = rob;
    endtask

    // Inputs are set at the negedge; reads checked, then the edge applied to the model.
    task automatic do_cycle();
        #1;
        compare_ports();
        @(posedge clockIn);
        if (resetIn) model_step();
        @(negedge clockIn);
    endtask

    initial begin
        logic [31:0] old_x5;
        resetIn = 1'b0;
        drive_idle();
        model_reset();
        bus.rs1Index = 5'd5;
        bus.rs2Index = 5'd31;
        #1;
        check_eq("reset_rs1_busy", 32'(bus.rs1Busy), 32'h0);
        check_eq("reset_rs1_value", bus.rs1Value, 32'h0);
        check_eq("reset_rs2_dep", 32'(bus.rs2Dep), 32'h0);
        @(negedge clockIn);
        resetIn = 1'b1;

        // Rename then commit.
        drive_idle(); drive_rename(5'd5, 4'd3); do_cycle();
        drive_idle(); bus.rs1Index = 5'd5; #1;
        check_eq("rc_busy", 32'(bus.rs1Busy), 32'h1);
        check_eq("rc_dep", 32'(bus.rs1Dep), 32'h3);
        do_cycle();
        drive_idle(); drive_commit(5'd5, 4'd3, 32'hDEADBEEF); do_cycle();
        drive_idle(); bus.rs1Index = 5'd5; #1;
        check_eq("rc_busy_after", 32'(bus.rs1Busy), 32'h0);
        check_eq("rc_value_after", bus.rs1Value, 32'hDEADBEEF);
        do_cycle();

        // Stale commit.
        drive_idle(); drive_rename(5'd7, 4'd2); do_cycle();
        drive_idle(); drive_rename(5'd7, 4'd6); do_cycle();
        drive_idle(); drive_commit(5'd7, 4'd2, 32'h11); do_cycle();
        drive_idle(); bus.rs1Index = 5'd7; #1;
        check_eq("stale_value", bus.rs1Value, 32'h11);
        check_eq("stale_busy", 32'(bus.rs1Busy), 32'h1);
        check_eq("stale_dep", 32'(bus.rs1Dep), 32'h6);
        do_cycle();

        // Same-cycle commit and rename to one register.
        drive_idle(); drive_commit(5'd9, 4'd1, 32'h22); drive_rename(5'd9, 4'd4); do_cycle();
        drive_idle(); bus.rs2Index = 5'd9; #1;
        check_eq("coll_value", bus.rs2Value, 32'h22);
        check_eq("coll_busy", 32'(bus.rs2Busy), 32'h1);
        check_eq("coll_dep", 32'(bus.rs2Dep), 32'h4);
        do_cycle();

        // Flush with a rename in the same cycle.
        for (int i = 1; i <= 3; i++) begin
            drive_idle();
            drive_commit(5'(i), 4'h0, 32'h100 + 32'(i));
            drive_rename(5'(i), 4'(i));
            do_cycle();
        end
        drive_idle(); bus.clear = 1'b1; drive_rename(5'd4, 4'd7); do_cycle();
        for (int i = 1; i < 32; i++) begin
            drive_idle(); bus.rs1Index = 5'(i); #1;
            check_eq($sformatf("clear_busy_x%0d", i), 32'(bus.rs1Busy), 32'h0);
            @(negedge clockIn);
        end
        for (int i = 1; i <= 4; i++) begin
            drive_idle(); bus.rs2Index = 5'(i); #1;
            check_eq($sformatf("clear_value_x%0d", i), bus.rs2Value, (i == 4) ? 32'h0 : 32'h100 + 32'(i));
            @(negedge clockIn);
        end

        // Writes to x0 are ignored.
        drive_idle(); drive_commit(5'd0, 4'd0, 32'hFFFFFFFF); drive_rename(5'd0, 4'd5); do_cycle();
        drive_idle(); bus.rs2Index = 5'd0; #1;
        check_eq("x0_value", bus.rs2Value, 32'h0);
        check_eq("x0_busy", 32'(bus.rs2Busy), 32'h0);
        do_cycle();

        // Commit observed on a read in the same cycle.
        old_x5 = 32'hDEADBEEF;
        drive_idle(); drive_rename(5'd5, 4'd3); do_cycle();
        drive_idle(); drive_commit(5'd5, 4'd3, 32'hAB); bus.rs1Index = 5'd5; #1;
`ifdef REG_FILE_BYPASS_EN
        check_eq("byp_value", bus.rs1Value, 32'hAB);
        check_eq("byp_busy", 32'(bus.rs1Busy), 32'h0);
`else
        check_eq("byp_value", bus.rs1Value, old_x5);
        check_eq("byp_busy", 32'(bus.rs1Busy), 32'h1);
`endif
        do_cycle();

        // Asynchronous reset mid-cycle; a rename presented during reset is lost.
        drive_idle(); drive_rename(5'd3, 4'd9); bus.rs1Index = 5'd5; bus.rs2Index = 5'd2;
        #2;
        resetIn = 1'b0;
        model_reset();
        #1;
        check_eq("areset_rs1_value", bus.rs1Value, 32'h0);
        check_eq("areset_rs2_value", bus.rs2Value, 32'h0);
        @(posedge clockIn);
        @(negedge clockIn);
        resetIn = 1'b1;
        drive_idle(); bus.rs1Index = 5'd3; #1;
        check_eq("areset_lost_busy", 32'(bus.rs1Busy), 32'h0);
        do_cycle();

        // Randomized traffic concentrated on a few registers to provoke collisions.
        for (int n = 0; n < 400; n++) begin
            int cd;
            drive_idle();
            cd = int'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) begin
                drive_commit(5'(cd), ($urandom_range(0, 1) == 1) ? m_tag[cd] : 4'($urandom),
                             $urandom);
            end
            if ($urandom_range(0, 1) == 1) drive_rename(5'($urandom_range(0, 7)), 4'($urandom));
            bus.clear    = ($urandom_range(0, 15) == 0);
            bus.rs1Index = ($urandom_range(0, 1) == 1) ? 5'(cd) : 5'($urandom_range(0, 31));
            bus.rs2Index = 5'($urandom_range(0, 7));
            do_cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
